// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the single regfile write port among NUM_REQ writeback sources.
// Latency: 1 cycle from accepted request (valid & ready) to the registered write port.
// Backpressure: req_ready is one-hot and combinational; stall or reset withholds every grant.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_reg,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    ctrl_writeEnable,
  output logic [4:0]              ctrl_writeReg,
  output logic [31:0]             data_writeReg,
  output logic [ID_W-1:0]         grant_id,
  output logic [CNT_W-1:0]        write_count
);

  // Round-robin pointer: the requester with highest priority this cycle.
  logic [ID_W-1:0] ptr;

  // Arbitration results.
  logic            found;
  logic [ID_W-1:0] sel_id;
  logic [4:0]      sel_reg;
  logic [31:0]     sel_data;
  logic            sel_nonzero;

  // Pick the first valid requester at or above ptr, else wrap to the lowest valid one.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    if (!ctrl_reset && !stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
          found  = 1'b1;
          sel_id = ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i]) begin
          found  = 1'b1;
          sel_id = ID_W'(i);
        end
      end
    end
  end

  // Decode the winner into the one-hot ready vector and mux out its payload.
  always_comb begin
    req_ready = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (sel_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_reg      = req_reg[5*i +: 5];
        sel_data     = req_data[32*i +: 32];
      end
    end
  end

  // Writes to $r0 are accepted but never reach the regfile or the counter.
  assign sel_nonzero = (sel_reg != 5'd0);

  // Advance the pointer past the requester that just transferred.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);
    end
  end

  // Registered write port; address, data and id hold when nothing transfers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= '0;
    end else begin
      ctrl_writeEnable <= found && sel_nonzero;
      if (found) begin
        ctrl_writeReg <= sel_reg;
        data_writeReg <= sel_data;
        grant_id      <= sel_id;
      end
    end
  end

  // Saturating count of writes actually issued to the regfile.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      write_count <= '0;
    end else if (found && sel_nonzero && (write_count != {CNT_W{1'b1}})) begin
      write_count <= write_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: scoreboard of expected write-port state, reference
// round-robin model, and a small regfile model fed from the DUT's write port.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int CNT_W   = 4;

  logic                  clock;
  logic                  ctrl_reset;
  logic                  stall;
  logic [NUM_REQ-1:0]    req_valid;
  logic [5*NUM_REQ-1:0]  req_reg;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  ctrl_writeEnable;
  logic [4:0]            ctrl_writeReg;
  logic [31:0]           data_writeReg;
  logic [ID_W-1:0]       grant_id;
  logic [CNT_W-1:0]      write_count;

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .stall           (stall),
    .req_valid       (req_valid),
    .req_reg         (req_reg),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .grant_id        (grant_id),
    .write_count     (write_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Regfile model: commits whatever the port presents, $r0 included, so a bad $r0 write shows.
  logic [31:0] rf [32];
  always @(posedge clock) begin
    if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
  end

  typedef struct packed {
    logic             we;
    logic [4:0]       wreg;
    logic [31:0]      wdata;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int failures;

  // Reference model state.
  int               m_ptr;
  logic [4:0]       m_reg;
  logic [31:0]      m_data;
  logic [ID_W-1:0]  m_id;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_reg  = '0;
    m_data = '0;
    m_id   = '0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic [1:0] v, input logic st,
                      input logic [4:0] r0, input logic [31:0] d0,
                      input logic [4:0] r1, input logic [31:0] d1);
    logic [NUM_REQ-1:0] exp_rdy;
    logic [4:0]         regs [NUM_REQ];
    logic [31:0]        datas[NUM_REQ];
    int                 win;
    exp_t               e;
    exp_t               got;
    req_valid = v;
    stall     = st;
    req_reg   = {r1, r0};
    req_data  = {d1, d0};
    regs[0] = r0; regs[1] = r1;
    datas[0] = d0; datas[1] = d1;
    #1;
    win = -1;
    if (!st) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (win < 0 && v[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_val("ready", req_ready, exp_rdy);
    e.we = 1'b0;
    if (win >= 0) begin
      m_reg  = regs[win];
      m_data = datas[win];
      m_id   = ID_W'(win);
      e.we   = (regs[win] != 5'd0);
      if (e.we && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_ptr  = (win + 1) % NUM_REQ;
    end
    e.wreg  = m_reg;
    e.wdata = m_data;
    e.id    = m_id;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    check_val("we",    ctrl_writeEnable, got.we);
    check_val("wreg",  ctrl_writeReg,    got.wreg);
    check_val("wdata", data_writeReg,    got.wdata);
    check_val("gid",   grant_id,         got.id);
    check_val("count", write_count,      got.cnt);
  endtask

  task automatic idle();
    step(2'b00, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  // Reset with both requesters asserting valid; entered and left at posedge+1.
  task automatic do_reset();
    ctrl_reset = 1'b1;
    req_valid  = 2'b11;
    stall      = 1'b0;
    req_reg    = {5'd2, 5'd1};
    req_data   = {32'h2222_2222, 32'h1111_1111};
    #1;
    check_val("rst_ready", req_ready, 0);
    check_val("rst_we",    ctrl_writeEnable, 0);
    check_val("rst_wreg",  ctrl_writeReg, 0);
    check_val("rst_wdata", data_writeReg, 0);
    check_val("rst_gid",   grant_id, 0);
    check_val("rst_count", write_count, 0);
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    req_valid  = 2'b00;
    model_reset();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ctrl_reset = 1'b1;
    stall      = 1'b0;
    req_valid  = '0;
    req_reg    = '0;
    req_data   = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    model_reset();
    @(posedge clock);
    #1;

    // Reset state with requests pending.
    do_reset();

    // Single write from requester 0, then read it back from the regfile model.
    step(2'b01, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
    idle();
    check_val("rf_r5", rf[5], 32'hDEAD_BEEF);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(2'b11, 1'b0, 5'd1, 32'hA000_0000 + i, 5'd2, 32'hB000_0000 + i);
    check_val("cnt_after_contention", write_count, 4);

    // $r0 write is accepted but not issued.
    step(2'b10, 1'b0, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    idle();
    check_val("rf_r0", rf[0], 32'd0);

    // Stall: nothing granted for 3 cycles, then the pointer (now 1) decides.
    step(2'b01, 1'b0, 5'd7, 32'h0000_0007, 5'd8, 32'h0000_0008);
    for (int i = 0; i < 3; i++)
      step(2'b11, 1'b1, 5'd9, 32'h0000_0009, 5'd10, 32'h0000_000A);
    step(2'b11, 1'b0, 5'd9, 32'h0000_0009, 5'd10, 32'h0000_000A);
    check_val("stall_release_gid", grant_id, 1);

    // Valid dropped before any grant leaves no trace.
    step(2'b01, 1'b1, 5'd11, 32'h0000_000B, 5'd0, 32'd0);
    idle();

    // Counter saturation over 20 grants.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(2'b11, 1'b0, 5'd3, $urandom, 5'd4, $urandom);
    check_val("cnt_sat", write_count, 15);

    // Reset in the middle of an outgoing write.
    step(2'b01, 1'b0, 5'd6, 32'h1234_5678, 5'd0, 32'd0);
    ctrl_reset = 1'b1;
    #1;
    check_val("async_we", ctrl_writeEnable, 0);
    check_val("async_cnt", write_count, 0);
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    model_reset();
    step(2'b11, 1'b0, 5'd12, 32'h0000_000C, 5'd13, 32'h0000_000D);
    check_val("post_reset_gid", grant_id, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
